ace_snapshot_loader: RTL and testbench
======================================

# ace_snapshot_loader

Upstream feeder for the Jupiter Ace core's loader port. Takes the byte stream of a compressed `.ace` snapshot from the HPS download channel. Expands its run-length encoding and drives `loader_en`/`loader_addr`/`loader_data`/`loader_wr` into the core, starting at 0x2000. Expanded data includes the register block at 0x2100–0x217F. On completion, `loader_addr` holds the end pointer that the core's post-load stack-pointer fix-up compares against.

## Interface
Parameters:
- `BASE_ADDR`, 16'h2000, address of the first expanded byte.
- `ESC_BYTE`, 8'hED, RLE escape marker.

Ports:
- `clk` in 1: system clock, single domain.
- `reset` in 1: synchronous, active-high.
- `ioctl_download` in 1: high for the duration of a snapshot download.
- `ioctl_wr` in 1: one-cycle strobe, compressed byte valid.
- `ioctl_dout` in 8: compressed byte.
- `ioctl_wait` out 1: back-pressure to the HPS. While high, the source issues no `ioctl_wr`.
- `loader_en` out 1: core held in loader mode.
- `loader_addr` out 16: target address of the current or next write.
- `loader_data` out 8: byte to write.
- `loader_wr` out 1: one-cycle write strobe.
- `overflow` out 1: sticky; expansion ran past 0xFFFF.

## Operation
Stream format:
- Any byte other than ESC_BYTE is a literal; write it once.
- The sequence ESC_BYTE, n, v with n = 1..255 writes v n times.
- The sequence ESC_BYTE, 0x00 is end-of-data. All later bytes of the download are accepted and discarded.

State machine (IDLE, GET, ESC, CNT, WR, ADV, DONE):
- IDLE: on rising `ioctl_download` → GET. Sets `loader_en`=1, `loader_addr`=BASE_ADDR, clears `overflow`.
- GET: on `ioctl_wr`:
  - byte == ESC_BYTE → ESC.
  - otherwise latch data and set run count = 1 → WR.
- ESC: on `ioctl_wr`:
  - byte == 0 → DONE.
  - otherwise latch it as the 8-bit run count → CNT.
- CNT: on `ioctl_wr`, latch the value → WR.
- WR: `loader_wr`=1 for exactly one cycle, `loader_addr`/`loader_data` stable. → ADV.
- ADV:
  - If `loader_addr`==0xFFFF, set `overflow` and hold `loader_addr`. Otherwise `loader_addr`+1.
  - Decrement the run count. If the count is now 0 → GET, else → WR.
  - While `overflow`=1, the WR state suppresses `loader_wr` (states still cycle, no write).
- DONE: discards input, holds `loader_addr`.

Download end:
- `ioctl_download` low while in GET, ESC, CNT or DONE → IDLE. `loader_en` falls that cycle.
- A truncated escape sequence is abandoned; no write is issued for it.
- `ioctl_download` low during WR/ADV: the current run completes, then → IDLE.
- `loader_addr` and `loader_data` keep their last values in IDLE. `loader_addr` = address one past the last written byte (or 0xFFFF if overflow).

`ioctl_wait` = 1 in WR and ADV, 0 otherwise (combinational from state).

## Timing
- Reset values: `loader_en`=0, `loader_wr`=0, `ioctl_wait`=0, `overflow`=0, `loader_addr`=BASE_ADDR, `loader_data`=0, state IDLE. Reset mid-run aborts immediately with no further `loader_wr`.
- Literal latency: `ioctl_wr` at cycle t → `loader_wr` at t+1. `ioctl_wait` is high at t+1 and t+2, low at t+3.
- Run of n: n writes, one every 2 cycles. `ioctl_wait` is high for 2n cycles, starting the cycle after the value byte.
- An `ioctl_wr` arriving in WR/ADV violates protocol and is ignored.
- A rising `ioctl_download` that coincides with `reset` is ignored (reset wins).
- `loader_en` rises the cycle after `ioctl_download` rises. It falls on the cycle IDLE is entered.
- The core requires `loader_en` to stay high through the last `loader_wr`. This is guaranteed by the rules above.

## Test plan
- Literals: download 41 42 43 → writes 0x2000=41, 0x2001=42, 0x2002=43. Final `loader_addr`=0x2003. `loader_en` falls one cycle after `ioctl_download` falls.
- Run: ED 05 AA 7F → 0x2000–0x2004=AA, 0x2005=7F. `ioctl_wait` high for 10 cycles after AA.
- Escaped marker plus end: ED 01 ED, ED 00, 11 22 → single write 0x2000=ED. Trailing bytes are discarded. Final `loader_addr`=0x2001.
- Overflow: literal prefix filling 0x2000–0xFFFD, then ED 04 55 → writes at 0xFFFE and 0xFFFF only. `overflow`=1, `loader_addr`=0xFFFF.
- Truncation: ED 03 then `ioctl_download` low → no write. IDLE next cycle, `loader_en`=0.
- Reset mid-run: ED FF 00, assert `reset` after the 10th write → `loader_wr` stops same cycle. All outputs at reset values. A new download restarts at 0x2000.

Source files
------------

// File: rtl/ace_snapshot_loader_if.sv
// Download channel and loader-port bundle for the Jupiter Ace snapshot loader.
// The master side is the HPS/bench and the slave side is the loader.
interface ace_snapshot_loader_if;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        loader_en;
    logic [15:0] loader_addr;
    logic [7:0]  loader_data;
    logic        loader_wr;
    logic        overflow;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_dout,
        input  ioctl_wait, loader_en, loader_addr,
        input  loader_data, loader_wr, overflow
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_dout,
        output ioctl_wait, loader_en, loader_addr,
        output loader_data, loader_wr, overflow
    );
endinterface

// File: rtl/ace_snapshot_loader.sv
// Expands an RLE-compressed .ace snapshot into Jupiter Ace loader-port writes.
// loader_addr is left one past the last byte written, for the SP fix-up.
module ace_snapshot_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h2000,
    parameter logic [7:0]  ESC_BYTE  = 8'hED
) (
    input  logic                  clk,
    input  logic                  reset,
    ace_snapshot_loader_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE, GET, ESC, CNT, WR, ADV, DONE
    } state_t;

    state_t      state, state_nx;
    logic [15:0] addr, addr_nx;
    logic [7:0]  data, data_nx;
    logic [7:0]  cnt, cnt_nx;
    logic        ovf, ovf_nx;
    logic        dl_q;
    logic        dl;
    logic        rise;

    assign dl   = bus.ioctl_download;
    assign rise = dl & ~dl_q;

    // Tracks the raw level even in reset so a rise during reset is lost.
    always_ff @(posedge clk) begin
        dl_q <= dl;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            addr  <= BASE_ADDR;
            data  <= 8'h00;
            cnt   <= 8'h00;
            ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            addr  <= addr_nx;
            data  <= data_nx;
            cnt   <= cnt_nx;
            ovf   <= ovf_nx;
        end
    end

    always_comb begin
        state_nx = state;
        addr_nx  = addr;
        data_nx  = data;
        cnt_nx   = cnt;
        ovf_nx   = ovf;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    state_nx = GET;
                    addr_nx  = BASE_ADDR;
                    ovf_nx   = 1'b0;
                end
            end
            GET: begin
                if (!dl) begin
                    state_nx = IDLE;
                end else if (bus.ioctl_wr) begin
                    if (bus.ioctl_dout == ESC_BYTE) begin
                        state_nx = ESC;
                    end else begin
                        data_nx  = bus.ioctl_dout;
                        cnt_nx   = 8'd1;
                        state_nx = WR;
                    end
                end
            end
            ESC: begin
                if (!dl) begin
                    state_nx = IDLE;
                end else if (bus.ioctl_wr) begin
                    if (bus.ioctl_dout == 8'h00) begin
                        state_nx = DONE;
                    end else begin
                        cnt_nx   = bus.ioctl_dout;
                        state_nx = CNT;
                    end
                end
            end
            CNT: begin
                if (!dl) begin
                    state_nx = IDLE;
                end else if (bus.ioctl_wr) begin
                    data_nx  = bus.ioctl_dout;
                    state_nx = WR;
                end
            end
            WR: begin
                state_nx = ADV;
            end
            ADV: begin
                if (addr == 16'hFFFF) begin
                    ovf_nx = 1'b1;
                end else begin
                    addr_nx = addr + 16'd1;
                end
                cnt_nx = cnt - 8'd1;
                // A run always finishes even if the download ended mid-run.
                if (cnt == 8'd1) begin
                    state_nx = dl ? GET : IDLE;
                end else begin
                    state_nx = WR;
                end
            end
            DONE: begin
                if (!dl) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign bus.loader_en   = (state != IDLE);
    assign bus.ioctl_wait  = (state == WR) || (state == ADV);
    assign bus.loader_wr   = (state == WR) && !ovf && !reset;
    assign bus.loader_addr = addr;
    assign bus.loader_data = data;
    assign bus.overflow    = ovf;
endmodule

// File: tb/tb_ace_snapshot_loader.sv
// Scoreboard bench for ace_snapshot_loader; a second instance based near
// 0xFFFF mirrors the stimulus so address wrap protection is reachable quickly.
module tb_ace_snapshot_loader;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ace_snapshot_loader_if bus ();
    ace_snapshot_loader_if hi ();

    assign hi.ioctl_download = bus.ioctl_download;
    assign hi.ioctl_wr       = bus.ioctl_wr;
    assign hi.ioctl_dout     = bus.ioctl_dout;

    ace_snapshot_loader #(.BASE_ADDR(16'h2000), .ESC_BYTE(8'hED)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    ace_snapshot_loader #(.BASE_ADDR(16'hFFF0), .ESC_BYTE(8'hED)) dut_hi (
        .clk(clk), .reset(reset), .bus(hi)
    );

    int vectors = 0;
    int miscompares = 0;
    int wr_cnt = 0;

    logic [23:0] exp_q[$];
    logic [23:0] exp_hi_q[$];
    logic [15:0] m_addr, m_hi_addr;
    logic        m_ovf, m_hi_ovf;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Reference model of the address pointer with saturation at 0xFFFF.
    task automatic expect_wr(logic [7:0] d, int n);
        for (int i = 0; i < n; i++) begin
            if (!m_ovf) begin
                exp_q.push_back({m_addr, d});
                if (m_addr == 16'hFFFF) m_ovf = 1'b1;
                else m_addr = m_addr + 16'd1;
            end
            if (!m_hi_ovf) begin
                exp_hi_q.push_back({m_hi_addr, d});
                if (m_hi_addr == 16'hFFFF) m_hi_ovf = 1'b1;
                else m_hi_addr = m_hi_addr + 16'd1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (bus.loader_wr === 1'b1) begin
            wr_cnt++;
            chk("en_on_wr", 32'(bus.loader_en), 32'd1);
            if (exp_q.size() == 0)
                chk("spurious_wr", 32'(exp_q.size()), 32'd1);
            else
                chk("wr", 32'({bus.loader_addr, bus.loader_data}),
                    32'(exp_q.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (hi.loader_wr === 1'b1) begin
            if (exp_hi_q.size() == 0)
                chk("hi_spurious_wr", 32'(exp_hi_q.size()), 32'd1);
            else
                chk("hi_wr", 32'({hi.loader_addr, hi.loader_data}),
                    32'(exp_hi_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(logic [7:0] b);
        int n = 0;
        while (bus.ioctl_wait && n < 2000) begin
            tick();
            n++;
        end
        if (bus.ioctl_wait) chk("wait_timeout", 32'(bus.ioctl_wait), 32'd0);
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_dout = b;
        tick();
        bus.ioctl_wr   = 1'b0;
    endtask

    task automatic start_dl();
        m_addr    = 16'h2000;
        m_hi_addr = 16'hFFF0;
        m_ovf     = 1'b0;
        m_hi_ovf  = 1'b0;
        bus.ioctl_download = 1'b1;
        tick();
        chk("en_rise", 32'(bus.loader_en), 32'd1);
        chk("start_addr", 32'(bus.loader_addr), 32'h2000);
        chk("start_ovf_hi", 32'(hi.overflow), 32'd0);
    endtask

    task automatic end_dl();
        int n = 0;
        while (bus.ioctl_wait && n < 2000) begin
            tick();
            n++;
        end
        bus.ioctl_download = 1'b0;
        tick();
        chk("en_fall", 32'(bus.loader_en), 32'd0);
        chk("q_left", 32'(exp_q.size()), 32'd0);
        chk("hi_q_left", 32'(exp_hi_q.size()), 32'd0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_en", 32'(bus.loader_en), 32'd0);
        chk("rst_wait", 32'(bus.ioctl_wait), 32'd0);
        chk("rst_wr", 32'(bus.loader_wr), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        chk("rst_addr", 32'(bus.loader_addr), 32'h2000);
        chk("rst_data", 32'(bus.loader_data), 32'h00);
    endtask

    initial begin
        int c;
        int w0;
        reset = 1'b1;
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr = 1'b0;
        bus.ioctl_dout = 8'h00;
        tick();
        tick();
        chk_reset_vals();

        // Download rising together with reset must be ignored.
        bus.ioctl_download = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("rst_wins", 32'(bus.loader_en), 32'd0);
        bus.ioctl_download = 1'b0;
        tick();

        // Literals with latency and wait profile.
        start_dl();
        expect_wr(8'h41, 1);
        send(8'h41);
        chk("lit_wr_t1", 32'(bus.loader_wr), 32'd1);
        chk("lit_wait_t1", 32'(bus.ioctl_wait), 32'd1);
        tick();
        chk("lit_wr_t2", 32'(bus.loader_wr), 32'd0);
        chk("lit_wait_t2", 32'(bus.ioctl_wait), 32'd1);
        tick();
        chk("lit_wait_t3", 32'(bus.ioctl_wait), 32'd0);
        expect_wr(8'h42, 1);
        send(8'h42);
        expect_wr(8'h43, 1);
        send(8'h43);
        end_dl();
        chk("lit_end_addr", 32'(bus.loader_addr), 32'h2003);

        // Run of five then a literal.
        start_dl();
        send(8'hED);
        send(8'h05);
        expect_wr(8'hAA, 5);
        send(8'hAA);
        c = 0;
        while (bus.ioctl_wait && c < 100) begin
            c++;
            tick();
        end
        chk("run_wait_len", 32'(c), 32'd10);
        expect_wr(8'h7F, 1);
        send(8'h7F);
        end_dl();
        chk("run_end_addr", 32'(bus.loader_addr), 32'h2006);

        // Escaped marker, end-of-data, discarded trailer.
        start_dl();
        send(8'hED);
        send(8'h01);
        expect_wr(8'hED, 1);
        send(8'hED);
        send(8'hED);
        send(8'h00);
        send(8'h11);
        send(8'h22);
        end_dl();
        chk("esc_end_addr", 32'(bus.loader_addr), 32'h2001);
        chk("esc_end_data", 32'(bus.loader_data), 32'hED);

        // Overflow on the high-based instance.
        start_dl();
        for (int i = 0; i < 14; i++) begin
            expect_wr(8'(8'h10 + i), 1);
            send(8'(8'h10 + i));
        end
        expect_wr(8'h55, 4);
        send(8'hED);
        send(8'h04);
        send(8'h55);
        end_dl();
        chk("hi_ovf", 32'(hi.overflow), 32'd1);
        chk("hi_ovf_addr", 32'(hi.loader_addr), 32'hFFFF);
        chk("lo_no_ovf", 32'(bus.overflow), 32'd0);
        chk("lo_ovf_addr", 32'(bus.loader_addr), 32'h2012);

        // Truncated escape sequence.
        start_dl();
        send(8'hED);
        send(8'h03);
        end_dl();
        chk("trunc_wait", 32'(bus.ioctl_wait), 32'd0);
        chk("trunc_addr", 32'(bus.loader_addr), 32'h2000);

        // Reset in the middle of a long run.
        start_dl();
        expect_wr(8'h00, 10);
        send(8'hED);
        send(8'hFF);
        w0 = wr_cnt;
        send(8'h00);
        c = 0;
        while (wr_cnt < w0 + 10 && c < 200) begin
            tick();
            c++;
        end
        if (wr_cnt < w0 + 10) chk("wr10_timeout", 32'(wr_cnt - w0), 32'd10);
        tick();
        reset = 1'b1;
        bus.ioctl_download = 1'b0;
        #1;
        chk("rst_kills_wr", 32'(bus.loader_wr), 32'd0);
        tick();
        tick();
        chk_reset_vals();
        chk("rst_q_left", 32'(exp_q.size()), 32'd0);
        chk("rst_hi_q_left", 32'(exp_hi_q.size()), 32'd0);
        reset = 1'b0;
        tick();
        start_dl();
        expect_wr(8'h5A, 1);
        send(8'h5A);
        end_dl();
        chk("restart_addr", 32'(bus.loader_addr), 32'h2001);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
